// File: rtl/clk_div_pkg.sv
// Shared types and divider field layout for the clock-enable divider controller.
package clk_div_pkg;

  typedef enum logic [1:0] {
    STOP = 2'd0,
    HOLD = 2'd1,
    RUN  = 2'd2
  } state_t;

  localparam int HI_MSB = 15;
  localparam int HI_LSB = 8;
  localparam int LO_MSB = 7;
  localparam int LO_LSB = 0;

  localparam logic [15:0] DEFAULT_DIV = 16'h1717;

  function automatic logic [7:0] div_hi(input logic [15:0] d);
    return d[HI_MSB:HI_LSB];
  endfunction

  function automatic logic [7:0] div_lo(input logic [15:0] d);
    return d[LO_MSB:LO_LSB];
  endfunction

endpackage

// File: rtl/clk_div_ctrl_if.sv
// Control/status bundle of the divider controller; master drives requests, slave is the controller.
interface clk_div_ctrl_if;

  logic        AClkHEn;
  logic        AEn;
  logic        ACfgWr;
  logic [15:0] ACfgData;
  logic        ACfgBusy;
  logic        AClkLvlO;
  logic        AClkEnO;
  logic        AResetON;
  logic [31:0] AStatus;

  modport master (
    output AClkHEn, AEn, ACfgWr, ACfgData,
    input  ACfgBusy, AClkLvlO, AClkEnO, AResetON, AStatus
  );

  modport slave (
    input  AClkHEn, AEn, ACfgWr, ACfgData,
    output ACfgBusy, AClkLvlO, AClkEnO, AResetON, AStatus
  );

endinterface

// File: rtl/clk_div_engine.sv
// Half-period down-counter and level toggle; boundary = counter empty while level is low.
// Frozen when en=0; clear forces the idle phase (count 0, level low).
module clk_div_engine (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       clear,
  input  logic       run,
  input  logic [7:0] hi_load,
  input  logic [7:0] lo_load,
  output logic       lvl,
  output logic       boundary
);

  logic [7:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= 8'd0;
      lvl <= 1'b0;
    end else if (en) begin
      if (clear) begin
        cnt <= 8'd0;
        lvl <= 1'b0;
      end else if (run) begin
        if (cnt != 8'd0) begin
          cnt <= cnt - 8'd1;
        end else begin
          lvl <= ~lvl;
          cnt <= lvl ? lo_load : hi_load;
        end
      end
    end
  end

  assign boundary = (cnt == 8'd0) && !lvl;

endmodule

// File: rtl/clk_div_ctrl.sv
// Divider controller: STOP/HOLD/RUN sequencing, shadowed divider applied at phase boundaries, reset hold.
// Optional status readback is built when CLK_DIV_CTRL_STATUS_EN is defined; otherwise AStatus reads zero.
module clk_div_ctrl
  import clk_div_pkg::*;
#(
  parameter logic [15:0]       CDivider       = DEFAULT_DIV,
  parameter int                CHoldW         = 8,
  parameter logic [CHoldW-1:0] CResetHold     = CHoldW'(8'h10),
  parameter bit                CResetOnChange = 1'b1
) (
  input  logic           AClkH,
  input  logic           AResetH,
  clk_div_ctrl_if.slave  bus
);

  state_t              state, state_next;
  logic [CHoldW-1:0]   hold, hold_next;
  logic [15:0]         active, shadow;
  logic                pend;
  logic                reset_on;
  logic                lvl, boundary, running, tick, apply;
  logic [7:0]          hi_load;

  assign running = (state != STOP);
  assign tick    = boundary && running && bus.AClkHEn;
  assign apply   = boundary && running && pend;
  // The reload on the applying boundary must already see the new high half-period.
  assign hi_load = apply ? div_hi(shadow) : div_hi(active);

  clk_div_engine u_engine (
    .clk      (AClkH),
    .rst      (AResetH),
    .en       (bus.AClkHEn),
    .clear    (state_next == STOP),
    .run      (running),
    .hi_load  (hi_load),
    .lo_load  (div_lo(active)),
    .lvl      (lvl),
    .boundary (boundary)
  );

  always_ff @(posedge AClkH) begin
    if (AResetH) begin
      state <= STOP;
      hold  <= CResetHold;
    end else if (bus.AClkHEn) begin
      state <= state_next;
      hold  <= hold_next;
    end
  end

  always_comb begin
    state_next = state;
    hold_next  = hold;
    case (state)
      STOP: begin
        if (bus.AEn) begin
          state_next = HOLD;
          hold_next  = CResetHold;
        end
      end
      HOLD: begin
        if (!bus.AEn) begin
          state_next = STOP;
        end else if (tick) begin
          if (hold == '0) state_next = RUN;
          else            hold_next  = hold - CHoldW'(1);
        end
      end
      RUN: begin
        if (!bus.AEn) begin
          state_next = STOP;
        end else if (apply && CResetOnChange) begin
          state_next = HOLD;
          hold_next  = CResetHold;
        end
      end
      default: state_next = STOP;
    endcase
  end

  always_ff @(posedge AClkH) begin
    if (AResetH) begin
      active   <= CDivider;
      shadow   <= CDivider;
      pend     <= 1'b0;
      reset_on <= 1'b0;
    end else if (bus.AClkHEn) begin
      reset_on <= (state_next == RUN);
      if (state == STOP) begin
        pend <= 1'b0;
        if (bus.ACfgWr) begin
          active <= bus.ACfgData;
          shadow <= bus.ACfgData;
        end
      end else if (!bus.AEn) begin
        // Leaving for STOP: any pending value becomes active immediately.
        pend   <= 1'b0;
        active <= bus.ACfgWr ? bus.ACfgData : shadow;
        if (bus.ACfgWr) shadow <= bus.ACfgData;
      end else begin
        if (apply) active <= shadow;
        if (bus.ACfgWr) begin
          shadow <= bus.ACfgData;
          pend   <= 1'b1;
        end else if (apply) begin
          pend <= 1'b0;
        end
      end
    end
  end

  assign bus.ACfgBusy = pend;
  assign bus.AClkLvlO = lvl;
  assign bus.AClkEnO  = tick;
  assign bus.AResetON = reset_on;

`ifdef CLK_DIV_CTRL_STATUS_EN
  logic [15:0] tick_cnt;
  logic [7:0]  hold_field;

  always_ff @(posedge AClkH) begin
    if (AResetH)                                   tick_cnt <= 16'd0;
    else if (bus.AClkHEn && tick && state == RUN)  tick_cnt <= tick_cnt + 16'd1;
  end

  assign hold_field  = (state == RUN) ? tick_cnt[7:0] : 8'(hold);
  assign bus.AStatus = {state, pend, 5'h0, hold_field, active};
`else
  assign bus.AStatus = 32'h0;
`endif

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Randomized + directed bench for clk_div_ctrl; phase-position reference model feeds a per-cycle scoreboard.
module tb_clk_div_ctrl;

  localparam logic [15:0] DIV0  = 16'h0201;
  localparam int          HOLD0 = 2;
  localparam bit          ROC   = 1'b1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  clk_div_ctrl_if bus();

  clk_div_ctrl #(
    .CDivider       (DIV0),
    .CHoldW         (8),
    .CResetHold     (8'(HOLD0)),
    .CResetOnChange (ROC)
  ) dut (
    .AClkH   (clk),
    .AResetH (rst),
    .bus     (bus)
  );

  typedef struct packed {
    logic        tick;
    logic        lvl;
    logic        rst_on;
    logic        busy;
    logic [2:0]  st;
    logic [15:0] act;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expect_v);
    n_chk++;
    if (actual !== expect_v) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, actual, expect_v, $time);
    end
  endtask

  // Reference model: position within the current period, 0 = boundary cycle.
  int          m_mode;   // 0 stop, 1 hold, 2 run
  int          m_hold, m_pos;
  logic [15:0] m_active, m_shadow;
  bit          m_pend, m_rst_on, m_valid = 1'b0;

  bit          c_rst = 1'b1, c_ce = 1'b0, c_en = 1'b0, c_wr = 1'b0;
  logic [15:0] c_data = 16'h0;

  function automatic int hi_of(input logic [15:0] d);
    return int'(d[15:8]);
  endfunction

  function automatic int period(input logic [15:0] d);
    return int'(d[15:8]) + int'(d[7:0]) + 2;
  endfunction

  task automatic model_edge();
    bit b, ap;
    if (c_rst) begin
      m_mode = 0; m_active = DIV0; m_shadow = DIV0; m_pend = 0;
      m_hold = HOLD0; m_pos = 0; m_rst_on = 0; m_valid = 1;
    end else if (m_valid && c_ce) begin
      if (m_mode == 0) begin
        if (c_wr) begin m_active = c_data; m_shadow = c_data; end
        if (c_en) begin m_mode = 1; m_hold = HOLD0; end
      end else if (!c_en) begin
        if (c_wr) m_shadow = c_data;
        m_active = m_shadow; m_pend = 0; m_mode = 0; m_pos = 0;
      end else begin
        b  = (m_pos == 0);
        ap = b && m_pend;
        if (ap) begin m_active = m_shadow; m_pend = 0; end
        m_pos = (m_pos + 1) % period(m_active);
        if (c_wr) begin m_shadow = c_data; m_pend = 1; end
        if (m_mode == 1 && b) begin
          if (m_hold == 0) m_mode = 2;
          else             m_hold--;
        end else if (m_mode == 2 && ap && ROC) begin
          m_mode = 1; m_hold = HOLD0;
        end
      end
      m_rst_on = (m_mode == 2);
    end
  endtask

  task automatic drive_and_push();
    exp_t e;
    rst          = c_rst;
    bus.AClkHEn  = c_ce;
    bus.AEn      = c_en;
    bus.ACfgWr   = c_wr;
    bus.ACfgData = c_data;
    if (m_valid) begin
      e.tick   = (m_mode != 0) && (m_pos == 0) && c_ce;
      e.lvl    = (m_mode != 0) && (m_pos >= 1) && (m_pos <= hi_of(m_active) + 1);
      e.rst_on = m_rst_on;
      e.busy   = m_pend;
      e.st     = {2'(m_mode), m_pend};
      e.act    = m_active;
      q.push_back(e);
    end
  endtask

  task automatic step(input bit en, input bit wr, input logic [15:0] d,
                      input bit ce = 1'b1, input bit r = 1'b0);
    @(posedge clk);
    model_edge();
    #1;
    c_en = en; c_wr = wr; c_data = d; c_ce = ce; c_rst = r;
    drive_and_push();
  endtask

  // Issue a write on the first running cycle whose phase position equals pos.
  task automatic wr_at(input int pos, input logic [15:0] d);
    bit hit = 1'b0;
    for (int i = 0; i < 60 && !hit; i++) begin
      @(posedge clk);
      model_edge();
      #1;
      hit = (m_mode != 0) && (m_pos == pos);
      c_en = 1'b1; c_wr = hit; c_data = d; c_ce = 1'b1; c_rst = 1'b0;
      drive_and_push();
    end
    check("wr_at_reached", 32'(hit), 32'd1);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      check("AClkEnO",  32'(bus.AClkEnO),  32'(e.tick));
      check("AClkLvlO", 32'(bus.AClkLvlO), 32'(e.lvl));
      check("AResetON", 32'(bus.AResetON), 32'(e.rst_on));
      check("ACfgBusy", 32'(bus.ACfgBusy), 32'(e.busy));
`ifdef CLK_DIV_CTRL_STATUS_EN
      check("status_hdr", 32'(bus.AStatus[31:29]), 32'(e.st));
      check("status_div", 32'(bus.AStatus[15:0]),  32'(e.act));
`else
      check("status_zero", bus.AStatus, 32'h0);
`endif
    end
  end

  initial begin
    bit en_r, wr_r, ce_r, r_r;
    logic [15:0] d_r;
    drive_and_push();
    repeat (3) step(1'b0, 1'b0, 16'h0, 1'b1, 1'b1);

    // Start-up: 5-cycle period, hold for three ticks then RUN.
    repeat (30) step(1'b1, 1'b0, 16'h0);

    // Write mid high phase, fastest divider, hold re-entered.
    wr_at(2, 16'h0000);
    repeat (20) step(1'b1, 1'b0, 16'h0);

    // Back to 5-cycle period, then two writes before one boundary.
    wr_at(1, 16'h0201);
    repeat (25) step(1'b1, 1'b0, 16'h0);
    wr_at(1, 16'h0303);
    step(1'b1, 1'b1, 16'h0101);
    repeat (30) step(1'b1, 1'b0, 16'h0);

    // Write landing exactly on a boundary while another is pending.
    wr_at(1, 16'h0201);
    wr_at(0, 16'h0102);
    repeat (30) step(1'b1, 1'b0, 16'h0);

    // Stop during HOLD with a pending write, then restart.
    repeat (2) step(1'b0, 1'b0, 16'h0);
    step(1'b1, 1'b0, 16'h0);
    wr_at(1, 16'h0300);
    step(1'b0, 1'b0, 16'h0);
    repeat (3) step(1'b0, 1'b0, 16'h0);
    repeat (30) step(1'b1, 1'b0, 16'h0);

    // Reset pulse mid-RUN, then a 7-cycle clock-enable gap.
    step(1'b1, 1'b0, 16'h0, 1'b1, 1'b1);
    repeat (25) step(1'b1, 1'b0, 16'h0);
    repeat (7) step(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
    repeat (10) step(1'b1, 1'b0, 16'h0);

    // Random traffic.
    repeat (1500) begin
      en_r = ($urandom_range(0, 39) != 0);
      wr_r = ($urandom_range(0, 14) == 0);
      d_r  = {8'($urandom_range(0, 5)), 8'($urandom_range(0, 5))};
      ce_r = ($urandom_range(0, 7) != 0);
      r_r  = ($urandom_range(0, 299) == 0);
      step(en_r, wr_r, d_r, ce_r, r_r);
    end

    step(1'b1, 1'b0, 16'h0);
    @(negedge clk);
    #1;
    check("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
